// File: rtl/write_back_stage.sv
// Write-back: selects the result, commits it to the register file, serves decode reads with same-cycle bypass.
// Commit/bypass/forward are zero latency; retire trace is one cycle; no backpressure (accepts every cycle).
module write_back_stage #(
  parameter int XLEN      = 32,
  parameter int REG_NUM   = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  input  logic [XLEN-1:0]      wb_pc,
  input  logic [XLEN-1:0]      wb_irreg_pc,
  input  logic [XLEN-1:0]      wb_r_data,
  input  logic [XLEN-1:0]      wb_alu_result,
  input  logic                 wb_is_load,
  input  logic                 wb_is_link,
  input  logic                 wb_rd_we,
  input  logic [4:0]           wb_rd_addr,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  output logic                 fwd_we,
  output logic [4:0]           fwd_addr,
  output logic [XLEN-1:0]      fwd_data,
  output logic [INSTRET_W-1:0] instret,
  output logic                 retire_valid,
  output logic [XLEN-1:0]      retire_pc
);

  logic [XLEN-1:0]      regs [REG_NUM];
  logic [XLEN-1:0]      result;
  logic                 commit;
  logic [INSTRET_W-1:0] instret_q;
  logic                 retire_valid_q;
  logic [XLEN-1:0]      retire_pc_q;

  // Load beats link beats ALU when both flags are set.
  always_comb begin
    result = wb_alu_result;
    if (wb_is_load) begin
      result = wb_r_data;
    end else if (wb_is_link) begin
      result = wb_irreg_pc;
    end
  end

  assign commit = wb_valid & wb_rd_we & (wb_rd_addr != 5'd0);

  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (commit && (rs1_addr == wb_rd_addr)) begin
      rs1_data = result;
    end
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (commit && (rs2_addr == wb_rd_addr)) begin
      rs2_data = result;
    end
  end

  assign fwd_we   = commit;
  assign fwd_addr = wb_rd_addr;
  assign fwd_data = result;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[wb_rd_addr] <= result;
    end
  end

  // Every valid instruction retires, including stores and branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q      <= '0;
      retire_valid_q <= 1'b0;
      retire_pc_q    <= '0;
    end else begin
      retire_valid_q <= wb_valid;
      if (wb_valid) begin
        instret_q   <= instret_q + 1'b1;
        retire_pc_q <= wb_pc;
      end
    end
  end

  assign instret      = instret_q;
  assign retire_valid = retire_valid_q;
  assign retire_pc    = retire_pc_q;

endmodule
